axi_lite_mailbox: RTL and testbench

AXI4-Lite slave holding a host-accessible word FIFO mailbox. It sits on a spare master port of the PCIe-to-AXI bridge's interconnect, beside the control register file. Host software pushes 32-bit words by writing DATA and pops them by reading DATA. STATUS reports fill level and sticky error flags, and CTRL provides flush and error clear.

---
 rtl/axi_lite_mailbox_pkg.sv | 13 +
 rtl/mailbox_fifo.sv | 59 +++++
 rtl/axi_lite_mailbox.sv | 122 ++++++++++++
 tb/tb_axi_lite_mailbox.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_mailbox_pkg.sv
// Shared constants for the AXI4-Lite mailbox: register word offsets, ID value
// and response codes.
package axi_lite_mailbox_pkg;
  localparam logic [1:0]  REG_ID     = 2'd0;
  localparam logic [1:0]  REG_STATUS = 2'd1;
  localparam logic [1:0]  REG_CTRL   = 2'd2;
  localparam logic [1:0]  REG_DATA   = 2'd3;

  localparam logic [31:0] MBOX_ID    = 32'h4D424F58;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
endpackage

// File: rtl/mailbox_fifo.sv
// Register-array word FIFO with flush. Pop is judged on the pre-cycle count;
// a push into a full FIFO still lands when a pop frees a slot in that cycle.
module mailbox_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          push_acc,
  output logic          pop_acc,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);
  assign dout     = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (flush)                    count_nxt = '0;
    else if (push_acc && !pop_acc) count_nxt = count + CW'(1);
    else if (!push_acc && pop_acc) count_nxt = count - CW'(1);
  end

  // Storage is deliberately not reset or cleared by flush.
  always_ff @(posedge clk)
    if (push_acc && !flush) mem[wr_ptr] <= din;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_acc) wr_ptr <= wr_ptr + AW'(1);
        if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end
endmodule

// File: rtl/axi_lite_mailbox.sv
// AXI4-Lite slave front end for the host mailbox: channel handshakes, address
// decode, sticky error flags and the STATUS/ID read mux around mailbox_fifo.
module axi_lite_mailbox
  import axi_lite_mailbox_pkg::*;
#(
  parameter int DEPTH              = 16,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          wr_fire, rd_fire, push, pop, flush, clr;
  logic          push_acc, pop_acc, full, empty, ovf, unf, ovf_nxt, unf_nxt;
  logic [1:0]    wsel, rsel, rresp_nxt;
  logic [31:0]   dout, rdata_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          unused_ok;

  assign wsel    = S_AXI_AWADDR[3:2];
  assign rsel    = S_AXI_ARADDR[3:2];
  assign wr_fire = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire = S_AXI_ARREADY && S_AXI_ARVALID;
  assign push    = wr_fire && (wsel == REG_DATA);
  assign pop     = rd_fire && (rsel == REG_DATA);
  assign flush   = wr_fire && (wsel == REG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
  assign clr     = wr_fire && (wsel == REG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];

  // A new error event in the clearing cycle survives the clear.
  assign ovf_nxt = (ovf && !clr) || (push && !push_acc);
  assign unf_nxt = (unf && !clr) || (pop && !pop_acc);

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                       S_AXI_WSTRB, full, empty, count};

  mailbox_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .din      (S_AXI_WDATA),
    .dout     (dout),
    .push_acc (push_acc),
    .pop_acc  (pop_acc),
    .count    (count),
    .count_nxt(count_nxt),
    .full     (full),
    .empty    (empty)
  );

  // STATUS is built from next-state so it includes the handshake edge itself.
  always_comb begin
    rdata_nxt = '0;
    rresp_nxt = RESP_OKAY;
    case (rsel)
      REG_ID:     rdata_nxt = MBOX_ID;
      REG_STATUS: rdata_nxt = {12'd0, unf_nxt, ovf_nxt, count_nxt == CW'(DEPTH),
                               count_nxt == '0, 16'(count_nxt)};
      REG_DATA: begin
        rdata_nxt = pop_acc ? dout : '0;
        rresp_nxt = pop_acc ? RESP_OKAY : RESP_SLVERR;
      end
      default:    rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
      ovf           <= 1'b0;
      unf           <= 1'b0;
    end else begin
      S_AXI_AWREADY <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
      S_AXI_WREADY  <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
      if (wr_fire) begin
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= (push && !push_acc) ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
      S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
      if (rd_fire) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rdata_nxt;
        S_AXI_RRESP  <= rresp_nxt;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
      ovf <= ovf_nxt;
      unf <= unf_nxt;
    end
  end
endmodule

// File: tb/tb_axi_lite_mailbox.sv
// Directed plus randomized bench for axi_lite_mailbox against a queue-based
// model of the mailbox register map.
module tb_axi_lite_mailbox;
  localparam int DEPTH = 16;

  logic        aclk, aresetn;
  logic [5:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int checks = 0, errors = 0;

  axi_lite_mailbox #(.DEPTH(DEPTH), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
    .S_AXI_ACLK(aclk), .S_AXI_ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Reference model: the mailbox contents as a plain queue plus two flags.
  logic [31:0] q[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0;

  function automatic logic [31:0] m_status();
    return {12'd0, m_unf, m_ovf, q.size() == DEPTH, q.size() == 0, 16'(q.size())};
  endfunction

  function automatic logic [1:0] m_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
    if (r == 2'd3) begin
      if (q.size() < DEPTH) begin q.push_back(d); return 2'b00; end
      m_ovf = 1'b1;
      return 2'b10;
    end
    if (r == 2'd2 && s[0]) begin
      if (d[0]) q.delete();
      if (d[1]) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end
    return 2'b00;
  endfunction

  function automatic void m_read(input logic [1:0] r, output logic [31:0] d, output logic [1:0] resp);
    d = 32'd0;
    resp = 2'b00;
    case (r)
      2'd0: d = 32'h4D424F58;
      2'd1: d = m_status();
      2'd3: if (q.size() > 0) d = q.pop_front();
            else begin m_unf = 1'b1; resp = 2'b10; end
      default: d = 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s,
                           input int gap, input int bdly, output logic [1:0] resp);
    int n;
    logic [1:0] hi;
    hi = 2'($urandom);
    repeat (gap) begin @(posedge aclk); #1; end
    awaddr = {hi, r, 2'b00}; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(posedge aclk); #1; n++; end while (!awready && n < 20);
    chk("aw_timeout", 64'(n < 20), 64'd1);
    chk("wready_with_awready", 64'(wready), 64'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_rise", 64'(bvalid), 64'd1);
    resp = bresp;
    repeat (bdly) begin
      @(posedge aclk); #1;
      chk("b_hold", 64'({bvalid, bresp}), 64'({1'b1, resp}));
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    chk("bvalid_drop", 64'(bvalid), 64'd0);
  endtask

  task automatic axi_read(input logic [1:0] r, input int gap, input int rdly,
                          output logic [31:0] d, output logic [1:0] resp);
    int n;
    logic [1:0] hi;
    hi = 2'($urandom);
    repeat (gap) begin @(posedge aclk); #1; end
    araddr = {hi, r, 2'b00}; arvalid = 1'b1;
    n = 0;
    do begin @(posedge aclk); #1; n++; end while (!arready && n < 20);
    chk("ar_timeout", 64'(n < 20), 64'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    chk("rvalid_rise", 64'(rvalid), 64'd1);
    d = rdata; resp = rresp;
    repeat (rdly) begin
      @(posedge aclk); #1;
      chk("r_hold", 64'({rvalid, rresp, rdata}), 64'({1'b1, resp, d}));
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    chk("rvalid_drop", 64'(rvalid), 64'd0);
  endtask

  task automatic do_wr(input string tag, input logic [1:0] r, input logic [31:0] d,
                       input logic [3:0] s, input int gap, input int dly);
    logic [1:0] resp, eresp;
    eresp = m_write(r, d, s);
    axi_write(r, d, s, gap, dly, resp);
    chk(tag, 64'(resp), 64'(eresp));
  endtask

  task automatic do_rd(input string tag, input logic [1:0] r, input int gap, input int dly);
    logic [31:0] d, ed;
    logic [1:0]  resp, eresp;
    m_read(r, ed, eresp);
    axi_read(r, gap, dly, d, resp);
    chk(tag, 64'({resp, d}), 64'({eresp, ed}));
  endtask

  logic [31:0] fd, fed, wv;
  logic [1:0]  fbr, frr, febr, ferr;

  initial begin
    aresetn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}), 64'd0);
    aresetn = 1'b1;

    do_rd("id_read", 2'd0, 0, 0);
    chk("status_literal_reset", 64'(m_status()), 64'h00010000);
    do_rd("status_reset", 2'd1, 1, 0);

    do_wr("push_11", 2'd3, 32'h11, 4'hF, 0, 0);
    do_wr("push_22", 2'd3, 32'h22, 4'h0, 1, 2);
    do_wr("push_33", 2'd3, 32'h33, 4'hF, 0, 0);
    for (int i = 0; i < 3; i++) do_rd("pop_order", 2'd3, i, i);
    do_rd("status_after_drain", 2'd1, 0, 0);

    for (int i = 0; i < DEPTH + 1; i++) do_wr("fill_push", 2'd3, $urandom, 4'hF, 0, 0);
    do_rd("status_full_ovf", 2'd1, 0, 0);
    for (int i = 0; i < DEPTH; i++) do_rd("drain_pop", 2'd3, 0, 0);

    do_rd("underflow_pop", 2'd3, 0, 3);
    do_rd("status_unf", 2'd1, 0, 0);
    do_wr("ctrl_clear", 2'd2, 32'h2, 4'h1, 0, 0);
    do_rd("status_cleared", 2'd1, 0, 0);

    for (int i = 0; i < 5; i++) do_wr("push5", 2'd3, $urandom, 4'hF, 0, 0);
    do_wr("ctrl_flush_nostrb", 2'd2, 32'h3, 4'hE, 0, 0);
    do_rd("status_nostrb", 2'd1, 0, 0);
    do_wr("ctrl_flush", 2'd2, 32'h1, 4'h1, 0, 0);
    do_rd("status_flushed", 2'd1, 0, 0);
    do_rd("pop_after_flush", 2'd3, 0, 0);
    do_wr("ctrl_both", 2'd2, 32'h3, 4'hF, 0, 0);
    do_rd("status_both", 2'd1, 0, 0);
    do_wr("write_id_ignored", 2'd0, $urandom, 4'hF, 0, 0);
    do_rd("ctrl_reads_zero", 2'd2, 0, 0);

    for (int i = 0; i < 80; i++) begin
      int op, gap, dly;
      op  = $urandom_range(0, 9);
      gap = $urandom_range(0, 3);
      dly = ($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 2);
      if (op < 5)      do_wr("rand_push", 2'd3, $urandom, 4'($urandom), gap, dly);
      else if (op < 9) do_rd("rand_pop", 2'd3, gap, dly);
      else             do_rd("rand_status", 2'd1, gap, dly);
    end

    while (q.size() < DEPTH) do_wr("refill", 2'd3, $urandom, 4'hF, 0, 0);
    wv = $urandom;
    m_read(2'd3, fed, ferr);
    febr = m_write(2'd3, wv, 4'hF);
    fork
      axi_write(2'd3, wv, 4'hF, 0, 0, fbr);
      axi_read(2'd3, 0, 0, fd, frr);
    join
    chk("simul_push_resp", 64'(fbr), 64'(febr));
    chk("simul_pop_data", 64'({frr, fd}), 64'({ferr, fed}));
    do_rd("status_simul_full", 2'd1, 0, 0);
    for (int i = 0; i < DEPTH; i++) do_rd("drain_after_simul", 2'd3, 0, 0);

    do_wr("pre_reset_push", 2'd3, 32'hA5A5, 4'hF, 0, 0);
    araddr = 6'h0C; arvalid = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    arvalid = 1'b0;
    chk("rvalid_before_reset", 64'(rvalid), 64'd1);
    aresetn = 1'b0;
    @(posedge aclk); #1;
    chk("reset_midflight", 64'({awready, wready, arready, bvalid, rvalid, rdata}), 64'd0);
    aresetn = 1'b1;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    do_rd("status_after_reset", 2'd1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
